// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: shared types and constants for the GMII transmit path
package eth_tx_pkg;
    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_DRAIN, S_IFG} state_t;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         EOF_BIT       = 8;
endpackage

// File: rtl/gmii_tx_framer_if.sv
// gmii_tx_framer_if: FIFO read port plus GMII transmit bundle
interface gmii_tx_framer_if;
    import eth_tx_pkg::*;
    logic               rd_empty;
    logic [EOF_BIT:0]   rd_data;
    logic               rd_en;
    logic [7:0]         txd;
    logic               tx_en;
    logic               tx_er;
    logic               frame_done;
    logic               underrun;
    modport master (input rd_empty, rd_data, output rd_en, txd, tx_en, tx_er, frame_done, underrun);
    modport slave  (output rd_empty, rd_data, input rd_en, txd, tx_en, tx_er, frame_done, underrun);
endinterface

// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: drains the TX FIFO into a GMII stream with preamble, SFD, padding, IFG and underrun abort
module gmii_tx_framer
    import eth_tx_pkg::*;
#(
    parameter int MIN_PAYLOAD = 60,
    parameter int IFG_LEN     = 12,
    parameter int PRE_LEN     = 7
) (
    input logic              i_rclk,
    input logic              i_arst,
    gmii_tx_framer_if.master io_bus
);
    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic [15:0] r_bytes, w_bytes_inc;
    logic        r_fv, r_last;
    logic [7:0]  r_txd, w_txd;
    logic        r_tx_en, r_tx_er, r_frame_done, r_underrun;
    logic        w_tx_en, w_tx_er, w_underrun, w_last;
    logic        w_rd_en, w_eof, w_short, w_pad_last, w_load_byte;

    assign w_eof       = r_fv && io_bus.rd_data[EOF_BIT];
    assign w_bytes_inc = (r_bytes == 16'hFFFF) ? r_bytes : r_bytes + 16'd1;
    assign w_short     = w_bytes_inc < 16'(MIN_PAYLOAD);
    assign w_pad_last  = w_bytes_inc >= 16'(MIN_PAYLOAD);
    assign w_load_byte = ((r_state == S_SFD || r_state == S_DATA) && r_fv) || r_state == S_PAD;
    // one pop in flight at most, and never beyond the byte carrying EOF
    assign w_rd_en = !io_bus.rd_empty && !w_eof &&
                     ((r_state == S_PREAMBLE && r_cnt == 8'd0) || r_state == S_SFD ||
                      r_state == S_DATA || r_state == S_DRAIN);

    always_ff @(posedge i_rclk or posedge i_arst)
        if (i_arst) r_state <= S_IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        w_next = io_bus.rd_empty ? S_IDLE : S_PREAMBLE;
            S_PREAMBLE:    w_next = (r_cnt == 8'd0) ? S_SFD : S_PREAMBLE;
            S_SFD, S_DATA: w_next = !r_fv ? S_DRAIN : !w_eof ? S_DATA : w_short ? S_PAD : S_IFG;
            S_PAD:         w_next = w_pad_last ? S_IFG : S_PAD;
            S_DRAIN:       w_next = w_eof ? S_IFG : S_DRAIN;
            S_IFG:         w_next = (r_cnt == 8'd0) ? S_IDLE : S_IFG;
            default:       w_next = S_IDLE;
        endcase
    end

    // values computed here appear on the GMII pins one cycle later
    always_comb begin
        w_tx_en    = 1'b0;
        w_tx_er    = 1'b0;
        w_txd      = 8'h00;
        w_underrun = 1'b0;
        w_last     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_en = !io_bus.rd_empty;
                w_txd   = io_bus.rd_empty ? 8'h00 : PREAMBLE_BYTE;
            end
            S_PREAMBLE: begin
                w_tx_en = 1'b1;
                w_txd   = (r_cnt == 8'd0) ? SFD_BYTE : PREAMBLE_BYTE;
            end
            S_SFD, S_DATA: begin
                w_tx_en    = 1'b1;
                w_txd      = r_fv ? io_bus.rd_data[7:0] : 8'h00;
                w_tx_er    = !r_fv;
                w_underrun = !r_fv;
                w_last     = w_eof && !w_short;
            end
            S_PAD: begin
                w_tx_en = 1'b1;
                w_last  = w_pad_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_rclk or posedge i_arst) begin
        if (i_arst) begin
            r_cnt        <= '0;
            r_bytes      <= '0;
            r_fv         <= 1'b0;
            r_last       <= 1'b0;
            r_txd        <= 8'h00;
            r_tx_en      <= 1'b0;
            r_tx_er      <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_cnt        <= (r_state == S_IDLE) ? 8'(PRE_LEN - 1) :
                            (w_next == S_IFG && r_state != S_IFG) ? 8'(IFG_LEN - 1) :
                            (r_cnt != 8'd0) ? r_cnt - 8'd1 : r_cnt;
            r_bytes      <= (r_state == S_IDLE) ? '0 : w_load_byte ? w_bytes_inc : r_bytes;
            r_fv         <= w_rd_en;
            r_last       <= w_last;
            r_frame_done <= r_last;
            r_txd        <= w_txd;
            r_tx_en      <= w_tx_en;
            r_tx_er      <= w_tx_er;
            r_underrun   <= w_underrun;
        end
    end

    assign io_bus.rd_en      = w_rd_en;
    assign io_bus.txd        = r_txd;
    assign io_bus.tx_en      = r_tx_en;
    assign io_bus.tx_er      = r_tx_er;
    assign io_bus.frame_done = r_frame_done;
    assign io_bus.underrun   = r_underrun;
endmodule

// File: doc/gmii_tx_framer.md
# gmii_tx_framer

Read-side drain stage that sits directly downstream of the async TX FIFO in the `rclk` domain. It pops bytes tagged with end-of-frame from the FIFO and emits a GMII transmit stream: 7-byte preamble, SFD, payload, zero-padding to minimum length, then enforced inter-frame gap. It detects FIFO underrun mid-frame, signals it on `tx_er` and discards the rest of that frame. FCS insertion is a separate, later stage.

## Interface
- `MIN_PAYLOAD`, 60: minimum payload bytes; shorter frames are zero-padded.
- `IFG_LEN`, 12: idle cycles enforced after every frame or abort.
- `PRE_LEN`, 7: preamble bytes before the SFD.
- `rclk` in 1: single clock, the FIFO read clock.
- `arst` in 1: asynchronous, active-high reset.
- `rd_empty` in 1: FIFO empty flag.
- `rd_data` in 9: FIFO read data; [7:0] byte, [8] end-of-frame (EOF).
- `rd_en` out 1: FIFO pop. Data is valid on `rd_data` in the cycle after `rd_en`.
- `txd` out 8: GMII transmit data, registered.
- `tx_en` out 1: GMII transmit enable, registered.
- `tx_er` out 1: GMII transmit error, registered.
- `frame_done` out 1: one-cycle pulse in the cycle after the last pad/data byte.
- `underrun` out 1: one-cycle pulse in the cycle `tx_er` first rises.

## Operation
- States: IDLE, PREAMBLE, SFD, DATA, PAD, DRAIN, IFG.
- IDLE: when `rd_empty` = 0, go to PREAMBLE.
- PREAMBLE: output `PRE_LEN` × 0x55, then go to SFD. SFD: output one 0xD5, then go to DATA.
- Fetch flag `fv`: set in the cycle after `rd_en`.
  - `rd_en` = 1 in the last PREAMBLE cycle and in every SFD/DATA cycle if all of these hold: `rd_empty` = 0, not (`fv` and `rd_data[8]`), and no EOF yet taken.
  - At most one pop is outstanding. No byte past EOF is ever popped.
- DATA: each cycle with `fv` = 1, output `rd_data[7:0]` and increment the 16-bit saturating byte counter.
  - When `rd_data[8]` = 1: if count+1 < `MIN_PAYLOAD`, go to PAD; otherwise go to IFG and pulse `frame_done`.
- PAD: output 0x00 with `tx_en` = 1 until count = `MIN_PAYLOAD`, then go to IFG and pulse `frame_done`.
- Underrun: in DATA with `fv` = 0 (nothing fetched), register `tx_en` = 1, `tx_er` = 1, `txd` = 0x00 for one cycle and pulse `underrun`.
  - Then go to DRAIN with `tx_en` = 0. In DRAIN, pop whenever `rd_empty` = 0 until a popped byte has EOF, then go to IFG.
- IFG: `tx_en` = 0 for `IFG_LEN` cycles, then go to IDLE. The FIFO is not read during IFG.
- A zero-length frame cannot occur: every frame carries at least its EOF byte.

## Timing
- Reset values: `txd` = 0x00, `tx_en` = 0, `tx_er` = 0, `rd_en` = 0, `frame_done` = 0, `underrun` = 0. State = IDLE, counters = 0.
- Reset asserted mid-frame:
  - Outputs clear immediately (async). The frame is truncated without `tx_er`.
  - The FIFO is reset on the same `arst` source, so no partial frame survives.
- T denotes the first cycle with `tx_en` = 1. `rd_empty` falling in cycle c gives T = c + 1.
- T … T+6: 0x55. T+7: 0xD5. T+8 onward: payload bytes, back-to-back while the FIFO stays non-empty.
- First `rd_en` occurs at T+6. The pop-to-`txd` latency is 2 cycles.
- Frame of N ≥ 60 bytes: `tx_en` high for 8 + N cycles. Frames shorter than 60 bytes: 68 cycles.
- After `tx_en` falls, at least `IFG_LEN` cycles pass before the next preamble.
- `rd_en` is combinational from state, `rd_empty`, `fv` and `rd_data[8]`.

## Structure
- Package `eth_tx_pkg`: state enum, `PREAMBLE_BYTE` = 8'h55, `SFD_BYTE` = 8'hD5, `EOF_BIT` = 8.
- Single module containing the FSM, the byte counter and the IFG/preamble down-counter.
- No sub-module is needed. The shared down-counter is inline.

## Test plan
- Reset mid-payload, then release: outputs are 0 during reset. The first frame after release starts with 7 × 0x55 and 0xD5.
- 64-byte frame preloaded (bytes 0x00–0x3F, EOF on the last byte):
  - `tx_en` is high 72 cycles with the exact byte sequence and `tx_er` = 0.
  - `frame_done` pulses once; exactly 64 pops occur.
- 10-byte frame: the 10 bytes are followed by 50 × 0x00; `tx_en` is high 68 cycles.
- Two 64-byte frames queued back-to-back: the gap between `tx_en` falling and rising is exactly 12 cycles.
- Underrun: `rd_empty` forced to 1 after payload byte 20 for 5 cycles, then the remaining bytes are supplied.
  - One `tx_er` cycle occurs with `tx_en` = 1, and `underrun` pulses.
  - The rest of the frame is drained silently, then IFG, and the next frame is transmitted intact.
- FIFO holding a 9-byte EOF frame plus the start of the next frame: no pop occurs after the EOF byte until the IFG completes.
